// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - CSR-side MMIO responder: console TX FIFO, status, 64-bit counters, scratch
// Single-cycle word accesses; read data is registered and holds until the next read.
module mmio_responder #(
  parameter int TX_DEPTH = 8,
  parameter int RETIRE_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                IN_ce,
  input  logic                IN_we,
  input  logic [3:0]          IN_wm,
  input  logic [29:0]         IN_addr,
  input  logic [31:0]         IN_data,
  output logic [31:0]         OUT_data,
  output logic                OUT_IO_busy,
  input  logic [RETIRE_W-1:0] IN_retire,
  output logic                OUT_tx_valid,
  output logic [7:0]          OUT_tx_data,
  input  logic                IN_tx_ready
);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0] r_data;
  logic [7:0]  r_mem [TX_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic        r_ovf;
  logic [63:0] r_cycle;
  logic [63:0] r_instret;
  logic [31:0] r_scratch;
  logic [31:0] r_hi;

  logic [2:0]  w_sel;
  logic        w_wr;
  logic        w_rd;
  logic        w_full;
  logic        w_pop;
  logic        w_push_req;
  logic        w_push;
  logic        w_drop;
  logic        w_ovf_clr;
  logic [7:0]  w_cnt8;
  logic [31:0] w_rdata;
  logic        w_unused_addr;

  assign w_sel         = IN_addr[2:0];
  assign w_unused_addr = ^IN_addr[29:3];
  assign w_wr          = !IN_ce && !IN_we;
  assign w_rd          = !IN_ce && IN_we;
  assign w_full        = (r_count == CW'(TX_DEPTH));
  assign w_pop         = OUT_tx_valid && IN_tx_ready;
  assign w_push_req    = w_wr && (w_sel == 3'd0) && IN_wm[0];
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign w_push        = w_push_req && (!w_full || w_pop);
  assign w_drop        = w_push_req && !w_push;
  assign w_ovf_clr     = w_wr && (w_sel == 3'd1) && IN_wm[0] && IN_data[2];
  assign w_cnt8        = 8'(r_count);

  assign OUT_data     = r_data;
  assign OUT_tx_valid = (r_count != '0);
  assign OUT_tx_data  = r_mem[r_rd_ptr];
  assign OUT_IO_busy  = w_full;

  always_comb begin
    w_rdata = 32'd0;
    case (w_sel)
      3'd1:    w_rdata = {16'd0, w_cnt8, 5'd0, r_ovf, (r_count == '0), w_full};
      3'd2:    w_rdata = r_cycle[31:0];
      3'd3:    w_rdata = r_hi;
      3'd4:    w_rdata = r_instret[31:0];
      3'd5:    w_rdata = r_hi;
      3'd6:    w_rdata = r_scratch;
      default: w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= IN_data[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data    <= 32'd0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_cycle   <= 64'd0;
      r_instret <= 64'd0;
      r_scratch <= 32'd0;
      r_hi      <= 32'd0;
    end else begin
      r_cycle   <= r_cycle + 64'd1;
      r_instret <= r_instret + 64'(IN_retire);
      if (w_rd) begin
        r_data <= w_rdata;
        // LO reads snapshot the upper half so a later HI read is coherent.
        if (w_sel == 3'd2) r_hi <= r_cycle[63:32];
        if (w_sel == 3'd4) r_hi <= r_instret[63:32];
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (w_wr && (w_sel == 3'd6) && IN_wm[k]) r_scratch[8*k +: 8] <= IN_data[8*k +: 8];
      end
    end
  end
endmodule

// File: tb/tb_mmio_responder.sv
// tb/tb_mmio_responder.sv - scoreboard bench for mmio_responder
// Inputs change on negedge; outputs are sampled on the following negedge.
module tb_mmio_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IN_ce = 1'b1;
  logic        IN_we = 1'b1;
  logic [3:0]  IN_wm = 4'd0;
  logic [29:0] IN_addr = 30'd0;
  logic [31:0] IN_data = 32'd0;
  logic [31:0] OUT_data;
  logic        OUT_IO_busy;
  logic [1:0]  IN_retire = 2'd0;
  logic        OUT_tx_valid;
  logic [7:0]  OUT_tx_data;
  logic        IN_tx_ready = 1'b0;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] rd_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] exp32;
  logic [7:0]  exp8;

  mmio_responder #(.TX_DEPTH(8), .RETIRE_W(2)) dut (
    .clk(clk), .rst(rst), .IN_ce(IN_ce), .IN_we(IN_we), .IN_wm(IN_wm),
    .IN_addr(IN_addr), .IN_data(IN_data), .OUT_data(OUT_data),
    .OUT_IO_busy(OUT_IO_busy), .IN_retire(IN_retire),
    .OUT_tx_valid(OUT_tx_valid), .OUT_tx_data(OUT_tx_data),
    .IN_tx_ready(IN_tx_ready)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
    IN_ce = 1'b0; IN_we = 1'b0; IN_addr = {27'd0, a}; IN_data = d; IN_wm = m;
    @(negedge clk);
    IN_ce = 1'b1; IN_we = 1'b1; IN_wm = 4'd0;
  endtask

  task automatic rd(input logic [2:0] a);
    IN_ce = 1'b0; IN_we = 1'b1; IN_addr = {27'd0, a};
    @(negedge clk);
    IN_ce = 1'b1;
  endtask

  task automatic test_reset;
    #1 rst = 1'b0;
    #2;
    n_total++; if (OUT_data !== 32'd0) $display("FAIL reset_data: got %h want 0", OUT_data); else n_pass++;
    n_total++; if (OUT_tx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", OUT_tx_valid); else n_pass++;
    n_total++; if (OUT_IO_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", OUT_IO_busy); else n_pass++;
    @(negedge clk); rst = 1'b1;
    rd_q.push_back(32'h0000_0002); rd(3'd1); exp32 = rd_q.pop_front();
    n_total++; if (OUT_data !== exp32) $display("FAIL status_empty: got %h want %h", OUT_data, exp32); else n_pass++;
  endtask

  task automatic test_fill_overflow;
    IN_tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr(3'd0, 32'h0000_0041 + i, 4'b0001);
      tx_q.push_back(8'h41 + 8'(i));
      if (i == 6) begin
        n_total++; if (OUT_IO_busy !== 1'b0) $display("FAIL busy_at7: got %b want 0", OUT_IO_busy); else n_pass++;
      end
    end
    n_total++; if (OUT_IO_busy !== 1'b1) $display("FAIL busy_at8: got %b want 1", OUT_IO_busy); else n_pass++;
    rd_q.push_back(32'h0000_0801); rd(3'd1); exp32 = rd_q.pop_front();
    n_total++; if (OUT_data !== exp32) $display("FAIL status_full: got %h want %h", OUT_data, exp32); else n_pass++;
    wr(3'd0, 32'h0000_0049, 4'b0001);
    rd_q.push_back(32'h0000_0805); rd(3'd1); exp32 = rd_q.pop_front();
    n_total++; if (OUT_data !== exp32) $display("FAIL status_ovf: got %h want %h", OUT_data, exp32); else n_pass++;
    wr(3'd1, 32'h0000_0004, 4'b0001);
    rd_q.push_back(32'h0000_0801); rd(3'd1); exp32 = rd_q.pop_front();
    n_total++; if (OUT_data !== exp32) $display("FAIL status_ovf_clr: got %h want %h", OUT_data, exp32); else n_pass++;
  endtask

  task automatic test_full_push_pop;
    IN_tx_ready = 1'b1;
    exp8 = tx_q.pop_front();
    n_total++; if (OUT_tx_data !== exp8) $display("FAIL pp_head: got %h want %h", OUT_tx_data, exp8); else n_pass++;
    wr(3'd0, 32'h0000_0050, 4'b0001);
    tx_q.push_back(8'h50);
    IN_tx_ready = 1'b0;
    rd_q.push_back(32'h0000_0801); rd(3'd1); exp32 = rd_q.pop_front();
    n_total++; if (OUT_data !== exp32) $display("FAIL pp_status: got %h want %h", OUT_data, exp32); else n_pass++;
    IN_tx_ready = 1'b1;
    for (int i = 0; i < 20 && tx_q.size() > 0; i++) begin
      exp8 = tx_q.pop_front();
      n_total++; if (OUT_tx_valid !== 1'b1) $display("FAIL drain_valid: got %b want 1", OUT_tx_valid); else n_pass++;
      n_total++; if (OUT_tx_data !== exp8) $display("FAIL drain_data: got %h want %h", OUT_tx_data, exp8); else n_pass++;
      @(negedge clk);
    end
    IN_tx_ready = 1'b0;
    n_total++; if (tx_q.size() != 0) $display("FAIL drain_bound: got %0d left want 0", tx_q.size()); else n_pass++;
    n_total++; if (OUT_tx_valid !== 1'b0) $display("FAIL drain_empty: got %b want 0", OUT_tx_valid); else n_pass++;
  endtask

  task automatic test_drain_two;
    wr(3'd0, 32'h0000_0041, 4'b0001); tx_q.push_back(8'h41);
    wr(3'd0, 32'h0000_0042, 4'b0001); tx_q.push_back(8'h42);
    IN_tx_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp8 = tx_q.pop_front();
      n_total++; if (OUT_tx_data !== exp8 || OUT_tx_valid !== 1'b1)
        $display("FAIL two_data: got %h/%b want %h/1", OUT_tx_data, OUT_tx_valid, exp8); else n_pass++;
      @(negedge clk);
    end
    n_total++; if (OUT_tx_valid !== 1'b0) $display("FAIL two_empty: got %b want 0", OUT_tx_valid); else n_pass++;
    IN_tx_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    wr(3'd6, 32'hDEAD_BEEF, 4'b1111);
    wr(3'd6, 32'h0000_00AA, 4'b0001);
    rd_q.push_back(32'hDEAD_BEAA); rd(3'd6); exp32 = rd_q.pop_front();
    n_total++; if (OUT_data !== exp32) $display("FAIL scratch_lo: got %h want %h", OUT_data, exp32); else n_pass++;
    wr(3'd6, 32'h0011_0000, 4'b0100);
    wr(3'd7, 32'h1234_5678, 4'b1111);
    rd_q.push_back(32'hDE11_BEAA); rd(3'd6); exp32 = rd_q.pop_front();
    n_total++; if (OUT_data !== exp32) $display("FAIL scratch_b2: got %h want %h", OUT_data, exp32); else n_pass++;
    rd_q.push_back(32'h0000_0000); rd(3'd7); exp32 = rd_q.pop_front();
    n_total++; if (OUT_data !== exp32) $display("FAIL reg7: got %h want %h", OUT_data, exp32); else n_pass++;
    rd_q.push_back(32'h0000_0000); rd(3'd0); exp32 = rd_q.pop_front();
    n_total++; if (OUT_data !== exp32) $display("FAIL tx_read: got %h want %h", OUT_data, exp32); else n_pass++;
  endtask

  task automatic test_cycle_snapshot;
    force dut.r_cycle = 64'h0000_0000_FFFF_FFFF;
    rd_q.push_back(32'hFFFF_FFFF); rd(3'd2); exp32 = rd_q.pop_front();
    release dut.r_cycle;
    n_total++; if (OUT_data !== exp32) $display("FAIL cycle_lo: got %h want %h", OUT_data, exp32); else n_pass++;
    @(negedge clk);
    rd_q.push_back(32'h0000_0000); rd(3'd3); exp32 = rd_q.pop_front();
    n_total++; if (OUT_data !== exp32) $display("FAIL cycle_hi_snap: got %h want %h", OUT_data, exp32); else n_pass++;
    rd(3'd2);
    rd_q.push_back(32'h0000_0001); rd(3'd3); exp32 = rd_q.pop_front();
    n_total++; if (OUT_data !== exp32) $display("FAIL cycle_hi_carry: got %h want %h", OUT_data, exp32); else n_pass++;
  endtask

  task automatic test_reset_mid;
    wr(3'd6, 32'hCAFE_0001, 4'b1111);
    for (int i = 0; i < 3; i++) wr(3'd0, 32'h0000_0061 + i, 4'b0001);
    rd_q.push_back(32'hCAFE_0001); rd(3'd6); exp32 = rd_q.pop_front();
    n_total++; if (OUT_data !== exp32) $display("FAIL pre_reset_data: got %h want %h", OUT_data, exp32); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++; if (OUT_tx_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", OUT_tx_valid); else n_pass++;
    n_total++; if (OUT_data !== 32'd0) $display("FAIL mid_reset_data: got %h want 0", OUT_data); else n_pass++;
    tx_q.delete();
    @(negedge clk); rst = 1'b1;
    IN_retire = 2'd3;
    rd_q.push_back(32'h0000_0000); rd(3'd2); exp32 = rd_q.pop_front();
    n_total++; if (OUT_data !== exp32) $display("FAIL cycle_restart: got %h want %h", OUT_data, exp32); else n_pass++;
    repeat (3) @(negedge clk);
    IN_retire = 2'd0;
    rd_q.push_back(32'd12); rd(3'd4); exp32 = rd_q.pop_front();
    n_total++; if (OUT_data !== exp32) $display("FAIL instret_lo: got %h want %h", OUT_data, exp32); else n_pass++;
    rd_q.push_back(32'h0000_0002); rd(3'd1); exp32 = rd_q.pop_front();
    n_total++; if (OUT_data !== exp32) $display("FAIL status_after_reset: got %h want %h", OUT_data, exp32); else n_pass++;
    rd_q.push_back(32'h0000_0000); rd(3'd6); exp32 = rd_q.pop_front();
    n_total++; if (OUT_data !== exp32) $display("FAIL scratch_after_reset: got %h want %h", OUT_data, exp32); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_fill_overflow;
    test_full_push_pop;
    test_drain_two;
    test_back_to_back;
    test_cycle_snapshot;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Memory-mapped IO responder on the CSR side of the load/store memory port.
- Services word accesses whose address top byte is 0xFF: a console TX byte FIFO, status, 64-bit cycle and instret counters, and a scratch register.
- Drives the IO-busy back-pressure that gates issue of further IO stores.
- Sits between the store/load port (CSR chip-enable) and the console UART transmitter.

Parameters:
- TX_DEPTH, 8, console TX FIFO depth in bytes (power of two, 2..64).
- RETIRE_W, 2, width of the per-cycle retired-instruction count.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- IN_ce  in  1  chip enable, active low
- IN_we  in  1  write enable, active low (1 = read)
- IN_wm  in  4  byte write mask, bit k enables data[8k+7:8k]
- IN_addr  in  30  word address; register select = IN_addr[2:0], other bits ignored
- IN_data  in  32  write data
- OUT_data  out  32  read data
- OUT_IO_busy  out  1  TX FIFO full
- IN_retire  in  RETIRE_W  instructions retired this cycle
- OUT_tx_valid  out  1  TX byte available
- OUT_tx_data  out  8  TX byte (FIFO head)
- IN_tx_ready  in  1  consumer accepts head byte

Behaviour:
- Reset (rst low, async), all cleared: OUT_data=0, FIFO count=0, read/write pointers=0, overflow=0, cycle=0, instret=0, scratch=0, hi-shadow=0. OUT_IO_busy=0, OUT_tx_valid=0.
- An access occurs on a rising edge with IN_ce=0. IN_we=0 is a write; IN_we=1 is a read.
- Read latency is 1: OUT_data is registered at the access edge and holds until the next read edge. Writes and idle cycles leave OUT_data unchanged.
- Register map (word index):
  - 0 TX: write with IN_wm[0]=1 pushes IN_data[7:0]; read returns 0.
  - 1 STATUS: read = {16'b0, count[7:0] zero-extended, 5'b0, overflow, empty, full}. Write with IN_wm[0] and IN_data[2]=1 clears overflow.
  - 2 CYCLE_LO: read returns cycle[31:0] and latches cycle[63:32] into hi-shadow on the same edge.
  - 3 CYCLE_HI: read returns hi-shadow.
  - 4 INSTRET_LO: read returns instret[31:0] and latches instret[63:32] into hi-shadow.
  - 5 INSTRET_HI: read returns hi-shadow.
  - 6 SCRATCH: read/write, byte-masked by IN_wm.
  - 7: reads 0, writes ignored.
  - Writes to indices 2-5 are ignored.
- Counters:
  - cycle += 1 every cycle out of reset; instret += IN_retire.
  - Both are 64-bit and wrap modulo 2^64.
  - Reads return the pre-update value present before the access edge.
- TX FIFO:
  - pop = OUT_tx_valid && IN_tx_ready.
  - A push is accepted if count<TX_DEPTH or pop occurs on the same edge. Otherwise the byte is dropped and overflow is set (sticky).
  - Push and pop on the same edge leave count unchanged.
  - Pointers wrap modulo TX_DEPTH. count width is clog2(TX_DEPTH)+1.
- Outputs from registered state (combinational decode only):
  - OUT_tx_valid = count!=0.
  - OUT_tx_data = mem[rdPtr].
  - OUT_IO_busy = count==TX_DEPTH.
  - OUT_IO_busy therefore updates the cycle after the push that fills the FIFO. The initiator's one-cycle post-IO-write hold covers that gap.
- Overflow set and clear on the same edge: set wins.
- Reset asserted mid-operation discards FIFO contents and pending read data immediately.

Test Plan:
- Reset, then read STATUS at edge n -> OUT_data after n = 0x00000002 (empty); OUT_tx_valid=0, OUT_IO_busy=0.
- IN_tx_ready=0, write TX with bytes 0x41..0x48 (8 writes), TX_DEPTH=8 -> OUT_IO_busy=1 the cycle after the 8th write; STATUS=0x00000801. A 9th write 0x49 is dropped and STATUS bit2=1. Write STATUS with data 0x4 clears it.
- Set IN_tx_ready=1 with the FIFO holding 0x41,0x42 -> OUT_tx_data=0x41 then 0x42 on consecutive cycles, then OUT_tx_valid=0. Full FIFO with simultaneous push 0x50 and pop -> count stays 8, no overflow, 0x50 emerges last.
- Force cycle to 0x00000000_FFFFFFFF (run 2^32-1 cycles or backdoor), read CYCLE_LO then CYCLE_HI two cycles later -> LO=0xFFFFFFFF and HI=0x00000000, from the snapshot, not the post-carry value.
- IN_retire=3 for 4 cycles from reset, then read INSTRET_LO -> 12. Write SCRATCH 0xDEADBEEF wm=4'b1111, then write 0x000000AA wm=4'b0001, then read -> 0xDEADBEAA.
- Assert rst low mid-burst with 3 bytes queued and a read pending -> OUT_tx_valid=0 and OUT_data=0 immediately, without waiting for a clock edge; after release, counters restart from 0.
